// File: rtl/hpu_pkg.sv
// Constants and types shared by the hypervector datapath blocks.
package hpu_pkg;

    localparam int HV_W       = 1024;
    localparam int OUT_W      = 64;
    localparam int BEATS      = HV_W / OUT_W;
    localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef struct packed {
        logic            last;
        logic [HV_W-1:0] d;
    } hv_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/hv_fifo.sv
// Synchronous FIFO of whole hypervector entries; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module hv_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  hpu_pkg::hv_entry_t    push_data,
    input  logic                  pop,
    output hpu_pkg::hv_entry_t    head,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] level
);
    import hpu_pkg::*;

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(DEPTH);

    hv_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage has no reset; a slot is only read after it was written, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/hv_stream_out.sv
// Buffers encoded hypervectors and serializes them into AXI4-Stream beats.
// Define HV_STREAM_OUT_CNT_EN to implement the sent_cnt vector counter.
module hv_stream_out #(
    parameter int DIM   = hpu_pkg::HV_W - 1,
    parameter int OUT_W = hpu_pkg::OUT_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_v,
    input  logic [DIM:0]           in_d,
    input  logic                   in_last,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [OUT_W-1:0]       m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level,
    output logic [31:0]            sent_cnt
);
    import hpu_pkg::*;

    localparam logic [BEAT_IDX_W-1:0]    LAST_IDX = BEAT_IDX_W'(BEATS - 1);
    localparam logic [BEAT_IDX_W-1:0]    IDX_ONE  = BEAT_IDX_W'(1);
    localparam logic [$clog2(DEPTH):0]   LVL_ONE  = ($clog2(DEPTH) + 1)'(1);

    ser_state_e                  state_q, state_d;
    logic [BEAT_IDX_W-1:0]       idx_q, idx_d;
    logic                        done_q, done_d;
    logic                        overflow_q, overflow_d;
    hv_entry_t                   wr_entry, head;
    logic                        full, empty;
    logic                        hs, last_beat, pop, wr_en;
    logic [BEATS-1:0][OUT_W-1:0] head_beats;

    assign hs         = m_axis_tvalid && m_axis_tready;
    assign last_beat  = (idx_q == LAST_IDX);
    assign pop        = hs && last_beat;
    assign wr_en      = in_v && (!full || pop);
    assign wr_entry   = '{last: in_last, d: in_d};
    assign head_beats = head.d;

    hv_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .push_data(wr_entry),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Look at post-edge occupancy so a fresh write starts sending next cycle
    // and back-to-back vectors leave no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty || wr_en) state_d = SEND;
            SEND:    if (pop && (level == LVL_ONE) && !wr_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = (state_q == SEND);
        m_axis_tdata  = m_axis_tvalid ? head_beats[idx_q] : '0;
        m_axis_tlast  = m_axis_tvalid && head.last && last_beat;
    end

    always_comb begin
        idx_d      = idx_q;
        if (hs) idx_d = last_beat ? '0 : idx_q + IDX_ONE;
        done_d     = hs && m_axis_tlast;
        overflow_d = overflow_q || (in_v && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef HV_STREAM_OUT_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = pop ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign sent_cnt = cnt_q;
`else
    assign sent_cnt = '0;
`endif

    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_hv_stream_out.sv
// Directed self-checking bench for hv_stream_out (either HV_STREAM_OUT_CNT_EN build).
module tb_hv_stream_out;

    localparam int HV_W  = 1024;
    localparam int OUT_W = 64;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_v = 1'b0;
    logic [HV_W-1:0]   in_d = '0;
    logic              in_last = 1'b0;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [OUT_W-1:0]  m_axis_tdata;
    logic              m_axis_tlast;
    logic              done;
    logic              overflow;
    logic [2:0]        level;
    logic [31:0]       sent_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sent = 0;
    logic [3:0] tr_pat = 4'b1001;

    hv_stream_out #(
        .DIM  (HV_W - 1),
        .OUT_W(OUT_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_v         (in_v),
        .in_d         (in_d),
        .in_last      (in_last),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .done         (done),
        .overflow     (overflow),
        .level        (level),
        .sent_cnt     (sent_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef HV_STREAM_OUT_CNT_EN
        return 32'(exp_sent);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [HV_W-1:0] ramp_vec();
        logic [HV_W-1:0] v;
        for (int i = 0; i < HV_W / 8; i++) v[i*8 +: 8] = 8'(i);
        return v;
    endfunction

    function automatic logic [HV_W-1:0] burst_vec(input int j);
        logic [HV_W-1:0] v;
        for (int k = 0; k < HV_W / OUT_W; k++) v[k*OUT_W +: OUT_W] = {8'(j), 40'h0, 8'hA5, 8'(k)};
        return v;
    endfunction

    task automatic push(input logic [HV_W-1:0] v, input logic last);
        in_v    = 1'b1;
        in_d    = v;
        in_last = last;
        step();
        in_v    = 1'b0;
    endtask

    // Receive one whole vector, checking order, tlast and stability under stalls.
    task automatic recv_vec(input string tag, input logic [HV_W-1:0] v, input logic last_exp,
                            input bit bp, input bit inject, input logic [HV_W-1:0] inj_v,
                            output int cycles);
        int hs = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [63:0] pd = '0;
        logic pl = 1'b0;
        while (hs < 16 && cyc < 200) begin
            in_v = 1'b0;
            m_axis_tready = bp ? tr_pat[cyc % 4] : 1'b1;
            if (stall) begin
                check({tag, "_hold_data"}, m_axis_tdata, pd);
                check({tag, "_hold_last"}, 64'(m_axis_tlast), 64'(pl));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check({tag, "_data"}, m_axis_tdata, v[hs*OUT_W +: OUT_W]);
                check({tag, "_last"}, 64'(m_axis_tlast), 64'((hs == 15) && last_exp));
                if (inject && hs == 15) begin
                    in_v    = 1'b1;
                    in_d    = inj_v;
                    in_last = 1'b0;
                end
                hs++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            pd    = m_axis_tdata;
            pl    = m_axis_tlast;
            step();
            cyc++;
        end
        in_v = 1'b0;
        check({tag, "_handshakes"}, 64'(hs), 64'd16);
        exp_sent++;
        cycles = cyc;
    endtask

    initial begin
        int cyc;

        // Reset state
        step();
        step();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_sent", 64'(sent_cnt), 64'd0);
        rst = 1'b0;
        step();

        // Single vector, tready held high
        m_axis_tready = 1'b1;
        push(ramp_vec(), 1'b1);
        check("t1_tvalid_rise", 64'(m_axis_tvalid), 64'd1);
        check("t1_level", 64'(level), 64'd1);
        check("t1_beat0", m_axis_tdata, 64'h0706050403020100);
        recv_vec("t1", ramp_vec(), 1'b1, 1'b0, 1'b0, '0, cyc);
        check("t1_cycles", 64'(cyc), 64'd16);
        check("t1_done", 64'(done), 64'd1);
        check("t1_idle", 64'(m_axis_tvalid), 64'd0);
        check("t1_level_empty", 64'(level), 64'd0);
        check("t1_sent", 64'(sent_cnt), 64'(exp_cnt()));
        step();
        check("t1_done_pulse", 64'(done), 64'd0);

        // Backpressure with tready 1,0,0,1 ...
        push(ramp_vec(), 1'b1);
        recv_vec("t2", ramp_vec(), 1'b1, 1'b1, 1'b0, '0, cyc);
        check("t2_done", 64'(done), 64'd1);
        check("t2_sent", 64'(sent_cnt), 64'(exp_cnt()));

        // Burst of 5 into a stalled stream: 5th is dropped
        m_axis_tready = 1'b0;
        step();
        for (int j = 0; j < 5; j++) begin
            push(burst_vec(j), j >= 3);
            check("t3_level", 64'(level), 64'((j < 4) ? j + 1 : 4));
            check("t3_overflow", 64'(overflow), 64'(j == 4));
        end
        check("t3_stall_head", m_axis_tdata, burst_vec(0)[63:0]);
        for (int j = 0; j < 4; j++) begin
            recv_vec("t3", burst_vec(j), j == 3, 1'b0, 1'b0, '0, cyc);
            check("t3_cycles", 64'(cyc), 64'd16);
        end
        check("t3_done", 64'(done), 64'd1);
        check("t3_drained", 64'(m_axis_tvalid), 64'd0);
        check("t3_level_end", 64'(level), 64'd0);
        check("t3_sent", 64'(sent_cnt), 64'(exp_cnt()));
        check("t3_overflow_sticky", 64'(overflow), 64'd1);

        // Reset during beat 7
        m_axis_tready = 1'b1;
        push(ramp_vec(), 1'b1);
        for (int i = 0; i < 7; i++) step();
        check("t5_beat7", m_axis_tdata, ramp_vec()[7*OUT_W +: OUT_W]);
        rst = 1'b1;
        step();
        exp_sent = 0;
        check("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_tlast", 64'(m_axis_tlast), 64'd0);
        check("t5_level", 64'(level), 64'd0);
        check("t5_overflow", 64'(overflow), 64'd0);
        check("t5_sent", 64'(sent_cnt), 64'd0);
        rst = 1'b0;
        step();
        check("t5_no_done", 64'(done), 64'd0);
        check("t5_still_idle", 64'(m_axis_tvalid), 64'd0);
        push(burst_vec(7), 1'b1);
        check("t5_restart_beat0", m_axis_tdata, burst_vec(7)[63:0]);
        recv_vec("t5", burst_vec(7), 1'b1, 1'b0, 1'b0, '0, cyc);
        check("t5_done", 64'(done), 64'd1);
        check("t5_sent_after", 64'(sent_cnt), 64'(exp_cnt()));

        // Write into a full FIFO on the same edge as the beat-15 pop
        m_axis_tready = 1'b0;
        for (int j = 10; j < 14; j++) push(burst_vec(j), j == 13);
        check("t4_full", 64'(level), 64'd4);
        recv_vec("t4", burst_vec(10), 1'b0, 1'b0, 1'b1, burst_vec(14), cyc);
        check("t4_level_kept", 64'(level), 64'd4);
        check("t4_no_overflow", 64'(overflow), 64'd0);
        for (int j = 11; j < 15; j++) begin
            recv_vec("t4", burst_vec(j), j == 13, 1'b0, 1'b0, '0, cyc);
            check("t4_cycles", 64'(cyc), 64'd16);
        end
        check("t4_drained", 64'(level), 64'd0);
        check("t4_idle", 64'(m_axis_tvalid), 64'd0);
        check("t4_sent", 64'(sent_cnt), 64'(exp_cnt()));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hv_stream_out.md
# hv_stream_out

Output-side streamer for the hypervector datapath. It accepts the DIM+1-bit encoded hypervectors that the bundling/sign stage presents one per `stream_v` strobe and buffers them in a small FIFO. It serializes each one into OUT_W-bit AXI4-Stream beats toward the DMA/ACP write path. The upstream stage has no backpressure, so the block absorbs bursts, reports overflow, and marks the end of a job with TLAST.

## Interface
Parameters:
- DIM, 1023 — hypervector MSB index; vector width is DIM+1.
- OUT_W, 64 — AXI-Stream data width. (DIM+1) must be a multiple of OUT_W.
- DEPTH, 4 — FIFO entries (whole vectors); power of two, ≥2.

Ports:
- clk  in  1  — single clock.
- rst  in  1  — synchronous, active-high reset.
- in_v  in  1  — one vector is presented this cycle.
- in_d  in  DIM+1  — vector data; sampled only when in_v=1.
- in_last  in  1  — the vector is the final one of the job; sampled with in_v.
- m_axis_tvalid  out  1  — beat valid.
- m_axis_tready  in  1  — downstream accepts the beat.
- m_axis_tdata  out  OUT_W  — beat data.
- m_axis_tlast  out  1  — final beat of a vector tagged in_last.
- done  out  1  — one-cycle pulse when the TLAST beat is accepted.
- overflow  out  1  — sticky; a vector was dropped.
- level  out  $clog2(DEPTH)+1  — current FIFO occupancy.
- sent_cnt  out  32  — vectors fully transmitted (see Configuration).

## Operation
- Reset values:
  - m_axis_tvalid, m_axis_tlast, done, overflow = 0.
  - level = 0, sent_cnt = 0.
  - m_axis_tdata = 0.
  - FIFO pointers and beat index = 0.
- Write path:
  - in_v=1 and the FIFO is not full: store {in_last, in_d} at the write pointer.
  - in_v=1 and the FIFO is full, with no pop in the same cycle: drop the vector, set overflow. Pointers are unchanged.
  - in_v=1 and the FIFO is full, with a pop in the same cycle: the write succeeds and level is unchanged.
- Serializer: BEATS = (DIM+1)/OUT_W (16 at defaults). The beat index runs 0..BEATS-1 on the FIFO head.
  - Beat k carries head_d[k*OUT_W +: OUT_W], LSB slice first.
- State machine:
  - IDLE: tvalid=0. Go to SEND when the FIFO is non-empty.
  - SEND: tvalid=1. On tready, increment the beat index.
  - On acceptance of beat BEATS-1: pop the head and reset the index to 0. Stay in SEND if another entry remains after the pop; otherwise go to IDLE.
- tlast = head_last AND (index == BEATS-1).
- done pulses for one cycle after the tlast beat is accepted.
- sent_cnt increments on every pop and wraps at 2^32.
- overflow clears only on rst.
- in_last does not flush or reset anything; the next vector starts a new job.

## Timing
- Write latency: a vector written at edge N can drive tvalid from cycle N+1 if the FIFO was empty.
- Throughput: one beat per cycle while tready=1. Back-to-back vectors have no bubble between beat BEATS-1 and the next head's beat 0.
- AXI rule: once tvalid=1, tdata and tlast hold stable until tready. tvalid never drops without a handshake, except on rst.
- level updates one edge after a write or pop. A simultaneous write and pop leaves level unchanged.
- Reset mid-transfer: at the rst edge, tvalid→0 and the partial vector is discarded. No tlast is emitted for it.
- Sustained input rate must be ≤1 vector per BEATS cycles; faster input overflows after DEPTH buffered vectors.

## Configuration
- Macro HV_STREAM_OUT_CNT_EN.
- Defined: the 32-bit sent_cnt register is implemented as above.
- Undefined: no counter logic; sent_cnt is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package hpu_pkg holds:
  - localparams HV_W = DIM+1 and OUT_W.
  - BEATS and the beat-index width.
  - typedef `hv_entry_t` = struct packed {logic last; logic [HV_W-1:0] d;}.
  - the serializer state enum {IDLE, SEND}.
- One sub-module, hv_fifo:
  - synchronous FIFO of hv_entry_t, DEPTH entries.
  - outputs full, empty and level.
  - same-cycle push and pop allowed when full.
- Serializer, handshake and counters live in hv_stream_out.

## Test plan
- Single vector: in_d = 1024'h…0F0E…0100 (byte i = i), in_last=1, tready=1. Required response:
  - 16 beats on consecutive cycles, tvalid rising one cycle after in_v.
  - Beat 0 = 64'h0706050403020100.
  - tlast on beat 15 only, done one cycle after, sent_cnt = 1.
- Backpressure: the same vector with tready toggling 1,0,0,1… Required response: tdata and tlast stay stable while tready=0, beats come out in order, and there are exactly 16 handshakes.
- Burst of 5 vectors on consecutive cycles with tready=0, then tready=1. Required response:
  - level saturates at 4 and overflow=1.
  - vectors 0–3 are transmitted and the 5th is absent.
  - sent_cnt = 4.
- Write to a full FIFO in the same cycle as the pop on beat 15. Required response: overflow stays 0 and level stays 4.
- Reset during beat 7:
  - tvalid=0 at the next edge; level=0, overflow=0, sent_cnt=0.
  - A new vector afterwards starts at beat 0.
- HV_STREAM_OUT_CNT_EN undefined: repeat the first scenario. Required response: sent_cnt reads 0 throughout and all stream outputs are identical.
